// File: rtl/tx_sample_scheduler_if.sv
// tx_sample_scheduler_if: audio, control and transmitter signals of the sample scheduler
interface tx_sample_scheduler_if #(parameter int DEPTH = 8);
  logic [7:0] audio;
  logic audio_valid;
  logic record_done;
  logic [7:0] ctrl;
  logic ctrl_valid;
  logic ctrl_ready;
  logic tx_busy;
  logic [7:0] tx_data;
  logic tx_valid;
  logic [$clog2(DEPTH):0] fifo_count;
  logic overflow;
  logic done;
  modport master (
    output audio, audio_valid, record_done, ctrl, ctrl_valid, tx_busy,
    input ctrl_ready, tx_data, tx_valid, fifo_count, overflow, done
  );
  modport slave (
    input audio, audio_valid, record_done, ctrl, ctrl_valid, tx_busy,
    output ctrl_ready, tx_data, tx_valid, fifo_count, overflow, done
  );
endinterface

// File: rtl/tx_sample_scheduler.sv
// tx_sample_scheduler: feeds audio FIFO, control byte and end-of-message byte to a one-byte-in-flight transmitter
module tx_sample_scheduler #(
  parameter int DEPTH = 8,
  parameter logic [7:0] EOM_BYTE = 8'hA5,
  parameter int START_TIMEOUT = 4
) (
  input logic clk,
  input logic rst_n,
  tx_sample_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(START_TIMEOUT) + 1;
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [TW-1:0] TMAX = TW'(START_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE} state_t;
  state_t state, state_d;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [7:0] ctrl_reg, tx_data, pick_byte;
  logic ctrl_full, eom_pending, rr_ctrl, eom_flight, tx_valid, overflow;
  logic [TW-1:0] timer;
  logic audio_req, full, pick_audio, pick_ctrl, pick_eom, issue, retry, pop, push;
  assign audio_req = count != '0;
  assign full = count == FULL;
  // round robin: audio wins a tie only when the previous pick was control
  assign pick_audio = audio_req && (!ctrl_full || rr_ctrl);
  assign pick_ctrl = ctrl_full && (!audio_req || !rr_ctrl);
  assign pick_eom = !audio_req && !ctrl_full && eom_pending;
  assign issue = state == IDLE && (audio_req || ctrl_full || eom_pending);
  assign retry = state == WAIT_START && !bus.tx_busy && timer == TMAX;
  assign pop = issue && pick_audio;
  assign push = bus.audio_valid && (!full || pop);
  assign pick_byte = pick_audio ? mem[rd_ptr] : pick_ctrl ? ctrl_reg : EOM_BYTE;
  assign bus.done = state == WAIT_DONE && !bus.tx_busy && eom_flight;
  assign bus.ctrl_ready = !ctrl_full;
  assign bus.fifo_count = count;
  assign bus.tx_data = tx_data;
  assign bus.tx_valid = tx_valid;
  assign bus.overflow = overflow;
  always_comb begin
    state_d = state;
    state_d = issue ? WAIT_START :
              (state == WAIT_START && bus.tx_busy) ? WAIT_DONE :
              (state == WAIT_DONE && !bus.tx_busy) ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.audio;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ctrl_reg <= '0;
      ctrl_full <= 1'b0;
      eom_pending <= 1'b0;
      rr_ctrl <= 1'b1;
      eom_flight <= 1'b0;
      timer <= '0;
      tx_valid <= 1'b0;
      tx_data <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (bus.ctrl_valid && !ctrl_full) begin
        ctrl_reg <= bus.ctrl;
        ctrl_full <= 1'b1;
      end else if (issue && pick_ctrl) ctrl_full <= 1'b0;
      eom_pending <= bus.done ? 1'b0 : eom_pending | bus.record_done;
      if (pop) rr_ctrl <= 1'b0;
      else if (issue && pick_ctrl) rr_ctrl <= 1'b1;
      if (issue) eom_flight <= pick_eom;
      timer <= (state == WAIT_START && !retry) ? timer + 1'b1 : '0;
      tx_valid <= issue || retry;
      if (issue) tx_data <= pick_byte;
      overflow <= overflow | (bus.audio_valid && full && !pop);
    end
endmodule

// File: tb/tb_tx_sample_scheduler.sv
// tb_tx_sample_scheduler: scenario tasks against a transmitter model and a round-robin merge reference
module tb_tx_sample_scheduler;
  localparam int DEPTH = 8;
  localparam logic [7:0] EOM = 8'hA5;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0, errors = 0;
  int cyc = 0, busy_cnt = 0, hold = 10, ignore_n = 0, dones = 0, done_cyc = -1, fall_cyc = -1;
  bit stall = 1'b0;
  logic [7:0] sent[$];
  int strobe_cyc[$];
  logic [7:0] ctrl_q[$];
  always #5 clk = ~clk;
  tx_sample_scheduler_if #(.DEPTH(DEPTH)) bus();
  tx_sample_scheduler #(.DEPTH(DEPTH), .EOM_BYTE(EOM), .START_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  // one clock: control feeder, transmitter model (busy 1 cycle after strobe, held hold cycles), done monitor
  task automatic step();
    bit acc;
    acc = bus.ctrl_valid && bus.ctrl_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) void'(ctrl_q.pop_front());
    bus.ctrl_valid = ctrl_q.size() > 0;
    if (ctrl_q.size() > 0) bus.ctrl = ctrl_q[0];
    if (stall) bus.tx_busy = 1'b1;
    else begin
      if (bus.tx_busy && busy_cnt == 0) fall_cyc = cyc;
      bus.tx_busy = busy_cnt > 0;
      if (busy_cnt > 0) busy_cnt--;
    end
    if (bus.tx_valid) begin
      sent.push_back(bus.tx_data);
      strobe_cyc.push_back(cyc);
      if (ignore_n > 0) ignore_n--;
      else if (!stall) busy_cnt = hold;
    end
    #1;
    if (bus.done) begin
      dones++;
      done_cyc = cyc;
    end
  endtask
  task automatic offer_ctrl(input logic [7:0] b);
    ctrl_q.push_back(b);
    bus.ctrl_valid = 1'b1;
    bus.ctrl = ctrl_q[0];
  endtask
  task automatic wait_sent(input int n, input int budget);
    int t;
    t = 0;
    while (sent.size() < n && t < budget) begin
      step();
      t++;
    end
  endtask
  task automatic clear_model();
    bus.audio = '0;
    bus.audio_valid = 1'b0;
    bus.record_done = 1'b0;
    bus.ctrl = '0;
    bus.ctrl_valid = 1'b0;
    bus.tx_busy = 1'b0;
    ctrl_q.delete();
    sent.delete();
    strobe_cyc.delete();
    busy_cnt = 0;
    ignore_n = 0;
    stall = 1'b0;
    dones = 0;
    done_cyc = -1;
    fall_cyc = -1;
  endtask
  task automatic apply_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask
  task automatic test_reset();
    clear_model();
    #2 rst_n = 1'b0;
    #2;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset tx_valid got %b want 0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset tx_data got %h want 00", bus.tx_data); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", bus.done); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset overflow got %b want 0", bus.overflow); end
    checks++; if (bus.ctrl_ready !== 1'b1) begin errors++; $display("FAIL reset ctrl_ready got %b want 1", bus.ctrl_ready); end
    checks++; if (bus.fifo_count !== '0) begin errors++; $display("FAIL reset fifo_count got %0d want 0", bus.fifo_count); end
    apply_reset();
  endtask
  task automatic test_single();
    int c0;
    apply_reset();
    hold = 100;
    c0 = cyc;
    bus.audio = 8'h3C;
    bus.audio_valid = 1'b1;
    step();
    bus.audio_valid = 1'b0;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL single early strobe got %b want 0", bus.tx_valid); end
    step();
    checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h3C) begin errors++; $display("FAIL single issue got valid %b data %h want 1 3c", bus.tx_valid, bus.tx_data); end
    checks++; if (bus.fifo_count !== '0) begin errors++; $display("FAIL single fifo_count got %0d want 0", bus.fifo_count); end
    repeat (110) step();
    checks++; if (sent.size() != 1 || strobe_cyc[0] != c0 + 2) begin errors++; $display("FAIL single strobes got %0d want 1 at cycle %0d", sent.size(), c0 + 2); end
    checks++; if (bus.tx_data !== 8'h3C) begin errors++; $display("FAIL single hold tx_data got %h want 3c", bus.tx_data); end
  endtask
  task automatic test_round_robin();
    logic [7:0] exp[3];
    exp = '{8'h11, 8'h80, 8'h22};
    apply_reset();
    hold = 20;
    bus.audio = 8'h11;
    bus.audio_valid = 1'b1;
    offer_ctrl(8'h80);
    step();
    bus.audio = 8'h22;
    step();
    bus.audio_valid = 1'b0;
    checks++; if (bus.ctrl_ready !== 1'b0) begin errors++; $display("FAIL rr ctrl_ready held got %b want 0", bus.ctrl_ready); end
    wait_sent(2, 200);
    checks++; if (sent.size() < 2) begin errors++; $display("FAIL rr timeout strobes %0d want 2", sent.size()); end
    checks++; if (bus.ctrl_ready !== 1'b1) begin errors++; $display("FAIL rr ctrl_ready after issue got %b want 1", bus.ctrl_ready); end
    wait_sent(3, 200);
    repeat (30) step();
    checks++; if (sent.size() != 3) begin errors++; $display("FAIL rr count got %0d want 3", sent.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= sent.size() || sent[i] !== exp[i]) begin errors++; $display("FAIL rr order[%0d] got %h want %h", i, (i < sent.size()) ? sent[i] : 8'hxx, exp[i]); end
    end
  endtask
  task automatic test_overflow();
    logic [7:0] exp[$];
    logic [7:0] v;
    apply_reset();
    hold = 5;
    stall = 1'b1;
    bus.audio = 8'h01;
    bus.audio_valid = 1'b1;
    exp.push_back(8'h01);
    step();
    bus.audio_valid = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 9; i++) begin
      v = 8'($urandom);
      if (i == 8) begin
        checks++; if (bus.fifo_count !== 4'd8 || bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf full got count %0d ovf %b want 8 0", bus.fifo_count, bus.overflow); end
      end else exp.push_back(v);
      bus.audio = v;
      bus.audio_valid = 1'b1;
      step();
    end
    bus.audio_valid = 1'b0;
    repeat (3) step();
    checks++; if (bus.fifo_count !== 4'd8 || bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf drop got count %0d ovf %b want 8 1", bus.fifo_count, bus.overflow); end
    stall = 1'b0;
    step();
    step();
    v = 8'($urandom);
    exp.push_back(v);
    bus.audio = v;
    bus.audio_valid = 1'b1;
    step();
    bus.audio_valid = 1'b0;
    checks++; if (bus.fifo_count !== 4'd8 || bus.tx_valid !== 1'b1) begin errors++; $display("FAIL ovf push_pop got count %0d valid %b want 8 1", bus.fifo_count, bus.tx_valid); end
    wait_sent(exp.size(), 400);
    repeat (20) step();
    checks++; if (sent.size() != exp.size()) begin errors++; $display("FAIL ovf count got %0d want %0d", sent.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= sent.size() || sent[i] !== exp[i]) begin errors++; $display("FAIL ovf order[%0d] got %h want %h", i, (i < sent.size()) ? sent[i] : 8'hxx, exp[i]); end
    end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf sticky got %b want 1", bus.overflow); end
  endtask
  task automatic test_eom();
    logic [7:0] s0, s1;
    int t;
    apply_reset();
    hold = 30;
    s0 = 8'($urandom);
    s1 = 8'($urandom);
    bus.audio = s0;
    bus.audio_valid = 1'b1;
    step();
    bus.audio = s1;
    step();
    bus.audio_valid = 1'b0;
    bus.record_done = 1'b1;
    step();
    bus.record_done = 1'b0;
    wait_sent(2, 200);
    repeat (5) step();
    bus.record_done = 1'b1;
    step();
    bus.record_done = 1'b0;
    t = 0;
    while (dones == 0 && t < 300) begin step(); t++; end
    checks++; if (dones != 1 || done_cyc != fall_cyc) begin errors++; $display("FAIL eom done got %0d pulses at cycle %0d want 1 at %0d", dones, done_cyc, fall_cyc); end
    repeat (60) step();
    checks++; if (sent.size() != 3 || dones != 1) begin errors++; $display("FAIL eom extra got %0d bytes %0d dones want 3 1", sent.size(), dones); end
    checks++; if (sent.size() < 3 || sent[0] !== s0 || sent[1] !== s1 || sent[2] !== EOM) begin errors++; $display("FAIL eom order got %p want %h %h a5", sent, s0, s1); end
  endtask
  task automatic test_retry();
    logic [7:0] v;
    apply_reset();
    hold = 10;
    ignore_n = 1;
    v = 8'($urandom) | 8'h01;
    bus.audio = v;
    bus.audio_valid = 1'b1;
    step();
    bus.audio_valid = 1'b0;
    wait_sent(2, 30);
    checks++; if (sent.size() < 2 || strobe_cyc[1] - strobe_cyc[0] != 4) begin errors++; $display("FAIL retry gap got %0d strobes want 2 spaced 4", sent.size()); end
    checks++; if (sent.size() < 2 || sent[0] !== v || sent[1] !== v) begin errors++; $display("FAIL retry data got %p want %h twice", sent, v); end
    repeat (25) step();
    checks++; if (sent.size() != 2 || bus.fifo_count !== '0) begin errors++; $display("FAIL retry settle got %0d strobes count %0d want 2 0", sent.size(), bus.fifo_count); end
  endtask
  task automatic test_async_reset();
    apply_reset();
    hold = 200;
    for (int i = 0; i < 4; i++) begin
      bus.audio = 8'($urandom) | 8'h01;
      bus.audio_valid = 1'b1;
      step();
    end
    bus.audio_valid = 1'b0;
    offer_ctrl(8'h5C);
    repeat (10) step();
    checks++; if (bus.fifo_count !== 4'd3 || bus.ctrl_ready !== 1'b0) begin errors++; $display("FAIL areset pre got count %0d ready %b want 3 0", bus.fifo_count, bus.ctrl_ready); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.fifo_count !== '0 || bus.ctrl_ready !== 1'b1) begin errors++; $display("FAIL areset regs got count %0d ready %b want 0 1", bus.fifo_count, bus.ctrl_ready); end
    checks++; if (bus.tx_data !== 8'h00 || bus.tx_valid !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL areset tx got data %h valid %b done %b want 00 0 0", bus.tx_data, bus.tx_valid, bus.done); end
    clear_model();
    #2 rst_n = 1'b1;
    repeat (40) step();
    checks++; if (sent.size() != 0 || bus.fifo_count !== '0) begin errors++; $display("FAIL areset after got %0d strobes count %0d want 0 0", sent.size(), bus.fifo_count); end
  endtask
  // reference: audio and control queues merged round robin (control counted as last after reset), then EOM
  task automatic test_random();
    logic [7:0] a[$], c[$], exp[$];
    int k, nc, ai, ci;
    bit eom, last_ctrl;
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      hold = $urandom_range(3, 15);
      stall = 1'b1;
      k = $urandom_range(1, DEPTH);
      nc = $urandom_range(0, 4);
      eom = 1'($urandom_range(0, 1));
      a.delete();
      c.delete();
      exp.delete();
      for (int i = 0; i < nc; i++) begin
        c.push_back(8'($urandom));
        offer_ctrl(c[i]);
      end
      for (int i = 0; i < k; i++) begin
        a.push_back(8'($urandom));
        bus.audio = a[i];
        bus.audio_valid = 1'b1;
        bus.record_done = eom && i == k - 1;
        step();
      end
      bus.audio_valid = 1'b0;
      bus.record_done = 1'b0;
      repeat (3) step();
      stall = 1'b0;
      ai = 0;
      ci = 0;
      last_ctrl = 1'b1;
      while (ai < a.size() || ci < c.size()) begin
        if (ai < a.size() && (ci >= c.size() || last_ctrl)) begin
          exp.push_back(a[ai]);
          ai++;
          last_ctrl = 1'b0;
        end else begin
          exp.push_back(c[ci]);
          ci++;
          last_ctrl = 1'b1;
        end
      end
      if (eom) exp.push_back(EOM);
      wait_sent(exp.size(), exp.size() * (hold + 10) + 50);
      repeat (hold + 10) step();
      checks++; if (sent.size() != exp.size()) begin errors++; $display("FAIL rand%0d count got %0d want %0d", r, sent.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (i >= sent.size() || sent[i] !== exp[i]) begin errors++; $display("FAIL rand%0d order[%0d] got %h want %h", r, i, (i < sent.size()) ? sent[i] : 8'hxx, exp[i]); end
      end
      checks++; if (dones != int'(eom)) begin errors++; $display("FAIL rand%0d done got %0d want %0d", r, dones, eom); end
      checks++; if (bus.fifo_count !== '0 || bus.ctrl_ready !== 1'b1 || bus.overflow !== 1'b0) begin errors++; $display("FAIL rand%0d idle got count %0d ready %b ovf %b want 0 1 0", r, bus.fifo_count, bus.ctrl_ready, bus.overflow); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_eom();
    test_retry();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_sample_scheduler.md
Name: tx_sample_scheduler

Overview:
Sequences 8-bit bytes into the pulse-width audio transmitter. It holds at most one byte in flight and issues the next byte only after the transmitter has finished the previous one. Buffers live 12 kHz audio samples in a FIFO and shares the transmitter with a single-entry control-byte channel using round-robin arbitration. After record_done, once the audio FIFO has drained, it appends an end-of-message byte and signals completion.

Parameters:
DEPTH, 8, audio FIFO depth in bytes; power of 2, >=2
EOM_BYTE, 8'hA5, byte sent after record_done once the audio FIFO is empty
START_TIMEOUT, 4, cycles to wait for tx_busy_in to rise before re-issuing the byte

Ports:
clk_in  input  1  system clock, 98.3 MHz
rst_n_in  input  1  asynchronous active-low reset
audio_in  input  8  audio sample
audio_valid_in  input  1  1-cycle strobe; audio_in is written to the FIFO
record_done_in  input  1  1-cycle strobe; recording has finished
ctrl_in  input  8  control byte
ctrl_valid_in  input  1  control byte offered; accepted when ctrl_valid_in && ctrl_ready_out
ctrl_ready_out  output  1  control holding register is empty
tx_busy_in  input  1  transmitter valid_out; high while a byte is being sent
tx_data_out  output  8  byte presented to the transmitter
tx_valid_out  output  1  1-cycle issue strobe to the transmitter
fifo_count_out  output  $clog2(DEPTH)+1  audio FIFO occupancy
overflow_out  output  1  sticky: an audio sample was dropped
done_out  output  1  1-cycle pulse after EOM_BYTE transmission completes

Behaviour:
- Reset (rst_n_in low, asynchronous) values:
  - tx_valid_out=0, tx_data_out=0, done_out=0, overflow_out=0.
  - ctrl_ready_out=1, fifo_count_out=0.
  - FIFO pointers=0, eom_pending=0, rr_last=ctrl, state=IDLE.
  - Reset mid-operation abandons the in-flight byte and discards all buffered data.
- FIFO:
  - Write on audio_valid_in.
  - Pop on issue of an audio byte.
  - Write when full and no simultaneous pop: sample dropped, overflow_out set until reset.
  - Write when full with a simultaneous pop: accepted, count unchanged.
  - Pointers wrap modulo DEPTH.
- Control channel:
  - One-entry holding register.
  - ctrl_ready_out drops the cycle after acceptance and rises the cycle after the control byte is issued.
- record_done_in sets eom_pending. A repeat strobe while pending is ignored.
- States:
  - IDLE: choose a source from those pending, audio (FIFO non-empty) and ctrl (register full).
    - If both are pending, alternate: pick the source not in rr_last.
    - If neither is pending and eom_pending, pick EOM.
    - On a pick: register tx_data_out, pulse tx_valid_out, pop the source, update rr_last (EOM leaves rr_last unchanged), go to WAIT_START.
  - WAIT_START: wait for tx_busy_in=1, then go to WAIT_DONE.
    - If START_TIMEOUT cycles elapse with no rise, re-pulse tx_valid_out with the same tx_data_out and restart the timer.
  - WAIT_DONE: wait for tx_busy_in=0, then go to IDLE.
    - If the completed byte was EOM: pulse done_out and clear eom_pending in the same cycle.
- Samples arriving after record_done are still sent before EOM while the FIFO is non-empty. EOM waits until the FIFO and the control register are both empty.
- tx_data_out holds its value between issues.
- Latency: with everything idle, audio_valid_in high in cycle 0 gives tx_valid_out high in cycle 2. That is one cycle for the FIFO write and one for the IDLE decision.
- The back-to-back gap is one cycle: IDLE re-entered, then the next issue.
- Throughput requirement: one byte is about 8×(200+up to 800)+1000 ≈ 9000 cycles. This is below the 8192-cycle 12 kHz sample period only if average byte content is favourable. DEPTH absorbs the burst; overflow_out flags any loss.

Test Plan:
- Single sample 0x3C in from idle; transmitter model raises busy 1 cycle after the strobe and holds it 100 cycles → tx_valid_out pulse in cycle 2 with tx_data_out=0x3C, no further strobe until busy falls, fifo_count_out returns to 0.
- Audio 0x11, 0x22 queued plus ctrl 0x80 offered; the first issue is audio because rr_last=ctrl after reset → issue order 0x11, 0x80, 0x22, and ctrl_ready_out rises after 0x80 is issued.
- Nine audio writes with busy held high (DEPTH=8) → fifo_count_out=8, the ninth sample is dropped, overflow_out=1 and stays 1; a subsequent write in the same cycle as a pop is accepted.
- record_done_in with 2 samples queued → order sample0, sample1, 0xA5; done_out pulses once, in the cycle busy falls after 0xA5; a second record_done_in while pending produces no extra EOM.
- Transmitter model ignores the first strobe → after 4 cycles tx_valid_out re-pulses with the same byte; busy then rises and the sequence completes normally.
- rst_n_in asserted in WAIT_DONE with 3 samples queued → outputs go to reset values immediately without a clock edge; after release, nothing is issued.
